dep_sync_ctrl: RTL and testbench
================================

Name: dep_sync_ctrl

Overview:
- Per-engine dependency synchronizer, the engine-side end of the P/V dependency-counter protocol.
- Accepts one instruction at a time from the engine's instruction queue.
- Holds each instruction until the dependency counters it waits on are positive.
- Then issues it to the execution datapath, generating the consume pulse (ok plus latched wait flags) toward the counters.
- On completion, generates the produce pulse (state_done plus latched release flags) toward neighbouring engines' counters.

Parameters:
- INST_W, 64, instruction payload width passed through to the datapath.
- DEP_W, 32, width of the dependency counter inputs, interpreted as two's-complement signed.
- STALL_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- inst_valid  in  1  instruction available
- inst_ready  out  1  instruction accepted when inst_valid & inst_ready
- inst_payload  in  INST_W  instruction body
- inst_wait_prev  in  1  instruction waits on counter from previous engine
- inst_wait_next  in  1  instruction waits on counter from next engine
- inst_release_prev  in  1  instruction releases previous engine on completion
- inst_release_next  in  1  instruction releases next engine on completion
- prev_dep_cnt  in  DEP_W  current value of this-after-prev counter
- next_dep_cnt  in  DEP_W  current value of this-after-next counter
- exec_start  out  1  one-cycle start pulse to datapath
- exec_payload  out  INST_W  latched instruction, stable from WAIT through DONE
- exec_done  in  1  datapath completion pulse
- ok  out  1  consume pulse; counters decrement where the matching wait flag is set
- wait_prev_o  out  1  latched inst_wait_prev
- wait_next_o  out  1  latched inst_wait_next
- state_done  out  1  produce pulse; neighbouring counters increment where the matching release flag is set
- release_prev_o  out  1  latched inst_release_prev
- release_next_o  out  1  latched inst_release_next
- busy  out  1  high in any state except IDLE
- stall_cycles  out  STALL_W  cumulative cycles spent blocked in WAIT, saturating

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - state = IDLE; inst_ready = 1.
  - exec_start, ok, state_done, busy, all latched flags = 0.
  - exec_payload = 0; stall_cycles = 0.
- Reset has priority at all times, including mid-instruction. The in-flight instruction is dropped and no ok or state_done is emitted.
- All outputs are registered.
- IDLE:
  - inst_ready = 1.
  - On inst_valid, latch payload and the four flags, then go to WAIT.
- WAIT:
  - Satisfied = (!wait_prev_o | $signed(prev_dep_cnt) > 0) & (!wait_next_o | $signed(next_dep_cnt) > 0).
  - Satisfied -> ISSUE next cycle.
  - Not satisfied -> stay in WAIT; stall_cycles increments by 1, holding at all-ones.
  - An instruction with no wait flags spends exactly one cycle in WAIT, and that cycle is not counted as a stall.
- ISSUE:
  - Exactly one cycle; ok = 1 and exec_start = 1, then go to EXEC.
  - The counter decrement lands at the end of this cycle.
  - Counter inputs are not sampled again until the next instruction's WAIT, which is at least 3 cycles later, so no stale-count double issue is possible.
- EXEC:
  - Wait for exec_done, then go to DONE.
  - Earliest legal exec_done is the cycle after ISSUE.
- DONE:
  - Exactly one cycle; state_done = 1, then go to IDLE.
  - Release flags remain valid during this cycle.
- Latched flags and exec_payload hold from WAIT through DONE and clear to 0 on return to IDLE.
- Pulse generation:
  - ok and state_done are never asserted in the same cycle.
  - At most one ok and one state_done per accepted instruction.
- exec_done outside EXEC is ignored and produces no state change.
- inst_valid outside IDLE is ignored; the instruction is not consumed, because inst_ready = 0.
- Counter values <= 0 (including negative, after a consume outran a produce) block issue.
- Counter value 0x7FFFFFFF counts as satisfied.
- Minimum instruction latency, accept to state_done:
  - accept cycle -> WAIT -> ISSUE -> EXEC -> DONE.
  - state_done fires 4 cycles after the accept edge when exec_done arrives on the first EXEC cycle.
- Back-to-back throughput is 1 instruction per 5 cycles minimum.

Test Plan:
- Reset, then check outputs -> inst_ready=1, busy=0, all pulses 0, stall_cycles=0.
- Instruction with no flags, exec_done on first EXEC cycle -> exec_start 2 cycles after accept, ok=1 with both wait_o=0, state_done 4 cycles after accept with both release_o=0, stall_cycles stays 0.
- wait_prev=1, prev_dep_cnt=0 for 7 cycles, then 1 -> stays in WAIT, stall_cycles=7; ok and exec_start pulse once with wait_prev_o=1; counter model decrements to 0.
- wait_prev=1 and wait_next=1, prev=2, next=-1 (0xFFFFFFFF) -> blocked; raising next to 1 issues on the following cycle.
- release_next=1 and release_prev=1 instruction, exec_done after 10 cycles -> single state_done with both release_o=1; spurious exec_done during WAIT ignored; inst_valid held during EXEC not consumed.
- Assert reset during EXEC, then post the next instruction -> no state_done emitted, returns to IDLE with stall_cycles=0, next instruction proceeds normally.

Source files
------------

// File: rtl/dep_sync_ctrl.sv
// Engine-side dependency synchronizer: holds each instruction until its
// P/V dependency counters are positive, then issues, executes and releases.
module dep_sync_ctrl #(
    parameter int INST_W  = 64,
    parameter int DEP_W   = 32,
    parameter int STALL_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_valid,
    output logic               inst_ready,
    input  logic [INST_W-1:0]  inst_payload,
    input  logic               inst_wait_prev,
    input  logic               inst_wait_next,
    input  logic               inst_release_prev,
    input  logic               inst_release_next,
    input  logic [DEP_W-1:0]   prev_dep_cnt,
    input  logic [DEP_W-1:0]   next_dep_cnt,
    output logic               exec_start,
    output logic [INST_W-1:0]  exec_payload,
    input  logic               exec_done,
    output logic               ok,
    output logic               wait_prev_o,
    output logic               wait_next_o,
    output logic               state_done,
    output logic               release_prev_o,
    output logic               release_next_o,
    output logic               busy,
    output logic [STALL_W-1:0] stall_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_ready;
    logic               r_busy;
    logic               r_ok;
    logic               r_start;
    logic               r_done;
    logic               r_wait_prev;
    logic               r_wait_next;
    logic               r_rel_prev;
    logic               r_rel_next;
    logic [INST_W-1:0]  r_payload;
    logic [STALL_W-1:0] r_stall;
    logic               w_accept;
    logic               w_prev_pos;
    logic               w_next_pos;
    logic               w_sat;

    // Strictly positive in two's complement: sign clear and non-zero.
    assign w_prev_pos = !prev_dep_cnt[DEP_W-1] && (|prev_dep_cnt);
    assign w_next_pos = !next_dep_cnt[DEP_W-1] && (|next_dep_cnt);
    assign w_sat      = (!r_wait_prev || w_prev_pos) &&
                        (!r_wait_next || w_next_pos);
    assign w_accept   = inst_valid && r_ready;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_WAIT;
            S_WAIT:  if (w_sat) w_next = S_ISSUE;
            S_ISSUE: w_next = S_EXEC;
            S_EXEC:  if (exec_done) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_ok        <= 1'b0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_wait_prev <= 1'b0;
            r_wait_next <= 1'b0;
            r_rel_prev  <= 1'b0;
            r_rel_next  <= 1'b0;
            r_payload   <= '0;
            r_stall     <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
            r_busy  <= (w_next != S_IDLE);
            r_ok    <= (w_next == S_ISSUE);
            r_start <= (w_next == S_ISSUE);
            r_done  <= (w_next == S_DONE);
            if (w_accept) begin
                r_wait_prev <= inst_wait_prev;
                r_wait_next <= inst_wait_next;
                r_rel_prev  <= inst_release_prev;
                r_rel_next  <= inst_release_next;
                r_payload   <= inst_payload;
            end else if (w_next == S_IDLE) begin
                r_wait_prev <= 1'b0;
                r_wait_next <= 1'b0;
                r_rel_prev  <= 1'b0;
                r_rel_next  <= 1'b0;
                r_payload   <= '0;
            end
            // Only blocked WAIT cycles count; the counter saturates.
            if (r_state == S_WAIT && !w_sat && r_stall != '1)
                r_stall <= r_stall + 1'b1;
        end
    end

    assign inst_ready     = r_ready;
    assign busy           = r_busy;
    assign ok             = r_ok;
    assign exec_start     = r_start;
    assign state_done     = r_done;
    assign wait_prev_o    = r_wait_prev;
    assign wait_next_o    = r_wait_next;
    assign release_prev_o = r_rel_prev;
    assign release_next_o = r_rel_next;
    assign exec_payload   = r_payload;
    assign stall_cycles   = r_stall;

endmodule

// File: tb/tb_dep_sync_ctrl.sv
// Scoreboard bench for dep_sync_ctrl: stimulus queues expected issue/done
// records, a negedge monitor pops and compares them as the pulses appear.
module tb_dep_sync_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [63:0] inst_payload = '0;
    logic        inst_wait_prev = 1'b0;
    logic        inst_wait_next = 1'b0;
    logic        inst_release_prev = 1'b0;
    logic        inst_release_next = 1'b0;
    logic [31:0] prev_dep_cnt;
    logic [31:0] next_dep_cnt;
    logic        exec_start;
    logic [63:0] exec_payload;
    logic        exec_done = 1'b0;
    logic        ok;
    logic        wait_prev_o;
    logic        wait_next_o;
    logic        state_done;
    logic        release_prev_o;
    logic        release_next_o;
    logic        busy;
    logic [31:0] stall_cycles;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] pl;
        logic        a;
        logic        b;
        logic [31:0] st;
    } exp_t;

    exp_t iss_q[$];
    exp_t done_q[$];
    exp_t mon_e;

    // Counter model: loaded by the bench, decremented by consume pulses.
    logic [31:0] m_prev = '0;
    logic [31:0] m_next = '0;
    logic        ld_p = 1'b0;
    logic        ld_n = 1'b0;
    logic [31:0] ld_pv = '0;
    logic [31:0] ld_nv = '0;

    assign prev_dep_cnt = m_prev;
    assign next_dep_cnt = m_next;

    always #5 clk = ~clk;

    dep_sync_ctrl #(.INST_W(64), .DEP_W(32), .STALL_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_payload(inst_payload),
        .inst_wait_prev(inst_wait_prev),
        .inst_wait_next(inst_wait_next),
        .inst_release_prev(inst_release_prev),
        .inst_release_next(inst_release_next),
        .prev_dep_cnt(prev_dep_cnt),
        .next_dep_cnt(next_dep_cnt),
        .exec_start(exec_start),
        .exec_payload(exec_payload),
        .exec_done(exec_done),
        .ok(ok),
        .wait_prev_o(wait_prev_o),
        .wait_next_o(wait_next_o),
        .state_done(state_done),
        .release_prev_o(release_prev_o),
        .release_next_o(release_next_o),
        .busy(busy),
        .stall_cycles(stall_cycles)
    );

    always @(posedge clk) begin
        if (ld_p) m_prev <= ld_pv;
        else if (ok && wait_prev_o) m_prev <= m_prev - 32'd1;
        if (ld_n) m_next <= ld_nv;
        else if (ok && wait_next_o) m_next <= m_next - 32'd1;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("ok_vs_start", {63'd0, ok}, {63'd0, exec_start});
            chk("ok_done_excl", {63'd0, ok & state_done}, 64'd0);
            if (exec_start) begin
                if (iss_q.size() == 0) begin
                    chk("unexpected_issue", 64'd1, 64'd0);
                end else begin
                    mon_e = iss_q.pop_front();
                    chk("issue_payload", exec_payload, mon_e.pl);
                    chk("wait_prev_o", {63'd0, wait_prev_o}, {63'd0, mon_e.a});
                    chk("wait_next_o", {63'd0, wait_next_o}, {63'd0, mon_e.b});
                end
            end
            if (state_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = done_q.pop_front();
                    chk("done_payload", exec_payload, mon_e.pl);
                    chk("release_prev_o", {63'd0, release_prev_o},
                        {63'd0, mon_e.a});
                    chk("release_next_o", {63'd0, release_next_o},
                        {63'd0, mon_e.b});
                    chk("done_stall", {32'd0, stall_cycles}, {32'd0, mon_e.st});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input logic [63:0] pl, input logic wp, input logic wn,
                        input logic rp, input logic rn, input logic [31:0] st);
        int n = 0;
        while (!inst_ready && n < 50) begin
            tick();
            n++;
        end
        chk("post_ready_timeout", {63'd0, n >= 50}, 64'd0);
        inst_valid        = 1'b1;
        inst_payload      = pl;
        inst_wait_prev    = wp;
        inst_wait_next    = wn;
        inst_release_prev = rp;
        inst_release_next = rn;
        iss_q.push_back('{pl, wp, wn, 32'd0});
        done_q.push_back('{pl, rp, rn, st});
        tick();
        inst_valid        = 1'b0;
        inst_payload      = '0;
        inst_wait_prev    = 1'b0;
        inst_wait_next    = 1'b0;
        inst_release_prev = 1'b0;
        inst_release_next = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!exec_start && n < 50);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!state_done && n < 50);
    endtask

    // Called from the ISSUE negedge; exec_done lands on EXEC cycle 'dly'.
    task automatic exec_pulse(input int dly);
        tick();
        repeat (dly - 1) tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        repeat (2) tick();
        chk("rst_ready", {63'd0, inst_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_pulses", {61'd0, ok, exec_start, state_done}, 64'd0);
        chk("rst_flags", {60'd0, wait_prev_o, wait_next_o,
            release_prev_o, release_next_o}, 64'd0);
        chk("rst_payload", exec_payload, 64'd0);
        chk("rst_stall", {32'd0, stall_cycles}, 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready", {63'd0, inst_ready}, 64'd1);

        // No flags: issue 2 cycles after accept, done 4 after.
        post(64'h1111_2222_3333_4444, 0, 0, 0, 0, 32'd0);
        chk("t2_busy", {63'd0, busy}, 64'd1);
        chk("t2_ready", {63'd0, inst_ready}, 64'd0);
        wait_start(n);
        chk("t2_start_lat", n, 2);
        exec_pulse(1);
        wait_done(n);
        chk("t2_done_lat", n, 1);
        chk("t2_stall", {32'd0, stall_cycles}, 64'd0);

        // wait_prev with a zero counter for 7 cycles, then 1.
        ld_p = 1'b1; ld_pv = 32'd0;
        tick();
        ld_p = 1'b0;
        post(64'hA5A5_0000_0000_0007, 1, 0, 0, 0, 32'd7);
        repeat (6) tick();
        ld_p = 1'b1; ld_pv = 32'd1;
        tick();
        ld_p = 1'b0;
        chk("t3_stall_mid", {32'd0, stall_cycles}, 64'd7);
        chk("t3_not_issued", {63'd0, ok}, 64'd0);
        wait_start(n);
        chk("t3_start_lat", n, 2);
        exec_pulse(1);
        wait_done(n);
        chk("t3_done_lat", n, 1);
        chk("t3_prev_cnt", {32'd0, m_prev}, 64'd0);

        // Both waits: prev=2, next=-1 blocks until next rises to 1.
        ld_p = 1'b1; ld_pv = 32'd2;
        ld_n = 1'b1; ld_nv = 32'hFFFF_FFFF;
        tick();
        ld_p = 1'b0; ld_n = 1'b0;
        post(64'hDEAD_BEEF_0000_0004, 1, 1, 0, 0, 32'd10);
        repeat (2) tick();
        ld_n = 1'b1; ld_nv = 32'd1;
        tick();
        ld_n = 1'b0;
        chk("t4_stall_mid", {32'd0, stall_cycles}, 64'd10);
        wait_start(n);
        chk("t4_start_lat", n, 2);
        exec_pulse(1);
        wait_done(n);
        chk("t4_done_lat", n, 1);
        chk("t4_prev_cnt", {32'd0, m_prev}, 64'd1);
        chk("t4_next_cnt", {32'd0, m_next}, 64'd0);

        // Release flags, spurious exec_done in WAIT, valid held in EXEC.
        post(64'h0123_4567_89AB_CDEF, 0, 0, 1, 1, 32'd10);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        wait_start(n);
        chk("t5_start_lat", n, 1);
        tick();
        inst_valid   = 1'b1;
        inst_payload = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 0; i < 9; i++) begin
            chk("t5_ready_exec", {63'd0, inst_ready}, 64'd0);
            tick();
        end
        inst_valid   = 1'b0;
        inst_payload = '0;
        exec_done    = 1'b1;
        tick();
        exec_done = 1'b0;
        wait_done(n);
        chk("t5_done_lat", n, 1);
        tick();
        chk("t5_idle_ready", {63'd0, inst_ready}, 64'd1);
        chk("t5_idle_busy", {63'd0, busy}, 64'd0);
        chk("t5_flags_clr", {62'd0, release_prev_o, release_next_o}, 64'd0);
        repeat (4) tick();

        // Reset during EXEC drops the instruction.
        post(64'h5555_6666_7777_8888, 0, 0, 1, 0, 32'd0);
        wait_start(n);
        chk("t6_start_lat", n, 2);
        tick();
        reset = 1'b1;
        void'(done_q.pop_back());
        tick();
        reset = 1'b0;
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_ready", {63'd0, inst_ready}, 64'd1);
        chk("t6_stall", {32'd0, stall_cycles}, 64'd0);
        chk("t6_payload", exec_payload, 64'd0);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        repeat (4) tick();
        chk("t6_no_done", {63'd0, state_done}, 64'd0);
        post(64'h9999_0000_AAAA_0001, 0, 0, 0, 1, 32'd0);
        wait_start(n);
        chk("t6b_start_lat", n, 2);
        exec_pulse(1);
        wait_done(n);
        chk("t6b_done_lat", n, 1);
        repeat (3) tick();

        chk("iss_q_empty", iss_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
